// File: rtl/game_pkg.sv
// Shared game definitions: screen geometry, missile state encoding and a
// small unsigned-distance helper used by the pixel tests.
package game_pkg;

  localparam logic [9:0] SCREEN_W = 10'd640;
  localparam logic [9:0] SCREEN_H = 10'd480;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FLYING   = 2'd1,
    COOLDOWN = 2'd2
  } missile_state_t;

  // |a - b| with the difference formed as an 11-bit two's-complement value
  function automatic logic [10:0] abs_diff11(input logic [9:0] a, input logic [9:0] b);
    logic [10:0] diff;
    diff = {1'b0, a} - {1'b0, b};
    if (diff[10]) begin
      return 11'd0 - diff;
    end else begin
      return diff;
    end
  endfunction

endpackage

// File: rtl/player_missile_if.sv
// Signal bundle between the game logic (master) and the player missile stage (slave).
interface player_missile_if;

  logic       frame_clk;
  logic       fire;
  logic       hit;
  logic [9:0] player_x_pos;
  logic [9:0] player_y_pos;
  logic [9:0] DrawX;
  logic [9:0] DrawY;
  logic [9:0] missile_x_pos;
  logic [9:0] missile_y_pos;
  logic       missile_active;
  logic       is_missile;

  modport master (
    output frame_clk, fire, hit, player_x_pos, player_y_pos, DrawX, DrawY,
    input  missile_x_pos, missile_y_pos, missile_active, is_missile
  );

  modport slave (
    input  frame_clk, fire, hit, player_x_pos, player_y_pos, DrawX, DrawY,
    output missile_x_pos, missile_y_pos, missile_active, is_missile
  );

endinterface

// File: rtl/frame_tick_gen.sv
// Turns the slow frame strobe into a single-Clk-cycle tick on its rising edge.
// Shared with the player block so both step on the same cycle.
module frame_tick_gen (
  input  logic Clk,
  input  logic Reset,
  input  logic frame_clk,
  output logic frame_tick
);

  logic frame_s1_q, frame_s1_d;
  logic frame_s2_q, frame_s2_d;

  // next-state for the two-stage strobe history
  always_comb begin
    frame_s1_d = frame_clk;
    frame_s2_d = frame_s1_q;
  end

  // strobe history registers
  always_ff @(posedge Clk) begin
    if (Reset) begin
      frame_s1_q <= 1'b0;
      frame_s2_q <= 1'b0;
    end else begin
      frame_s1_q <= frame_s1_d;
      frame_s2_q <= frame_s2_d;
    end
  end

  assign frame_tick = frame_s1_q & ~frame_s2_q;

endmodule

// File: rtl/player_missile.sv
// Single player missile: launched above the player on a fire press, climbs one
// step per frame until it leaves the top or is hit, then reloads for a while.
module player_missile
  import game_pkg::*;
#(
  parameter logic [9:0] Missile_Y_Step  = 10'd8,
  parameter logic [9:0] Missile_Y_Min   = 10'd0,
  parameter logic [9:0] Launch_Offset   = 10'd8,
  parameter logic [9:0] Missile_Half_W  = 10'd1,
  parameter logic [9:0] Missile_Half_H  = 10'd4,
  parameter logic [4:0] Cooldown_Frames = 5'd15
) (
  input logic             Clk,
  input logic             Reset,
  player_missile_if.slave bus
);

  missile_state_t state_q, state_d;
  logic [9:0]     x_q, x_d;
  logic [9:0]     y_q, y_d;
  logic [4:0]     cool_cnt_q, cool_cnt_d;
  logic           fire_req_q, fire_req_d;
  logic           fire_dly_q, fire_dly_d;
  logic           active_q, active_d;
  logic           frame_tick;
  logic           fire_rise;

  frame_tick_gen u_frame_tick (
    .Clk        (Clk),
    .Reset      (Reset),
    .frame_clk  (bus.frame_clk),
    .frame_tick (frame_tick)
  );

  assign fire_rise = bus.fire & ~fire_dly_q;

  // next-state, position, cooldown and fire-request computation
  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    cool_cnt_d = cool_cnt_q;
    fire_req_d = 1'b0;
    fire_dly_d = bus.fire;

    case (state_q)
      IDLE: begin
        if (frame_tick && fire_req_q) begin
          state_d = FLYING;
          x_d     = bus.player_x_pos;
          y_d     = bus.player_y_pos - Launch_Offset;
        end else begin
          fire_req_d = fire_req_q | fire_rise;
        end
      end
      FLYING: begin
        // a hit wins over a coincident tick so the reported Y stays put
        if (bus.hit) begin
          state_d    = COOLDOWN;
          cool_cnt_d = Cooldown_Frames;
        end else if (frame_tick) begin
          if (y_q < Missile_Y_Min + Missile_Y_Step) begin
            state_d    = COOLDOWN;
            cool_cnt_d = Cooldown_Frames;
          end else begin
            y_d = y_q - Missile_Y_Step;
          end
        end else begin
          state_d = FLYING;
        end
      end
      COOLDOWN: begin
        if (frame_tick) begin
          if (cool_cnt_q == 5'd0) begin
            state_d = IDLE;
          end else begin
            cool_cnt_d = cool_cnt_q - 5'd1;
          end
        end else begin
          state_d = COOLDOWN;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    active_d = (state_d == FLYING);
  end

  // missile state machine registers
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= IDLE;
      x_q        <= 10'd0;
      y_q        <= 10'd0;
      cool_cnt_q <= 5'd0;
      fire_req_q <= 1'b0;
      fire_dly_q <= 1'b0;
      active_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      cool_cnt_q <= cool_cnt_d;
      fire_req_q <= fire_req_d;
      fire_dly_q <= fire_dly_d;
      active_q   <= active_d;
    end
  end

  assign bus.missile_x_pos  = x_q;
  assign bus.missile_y_pos  = y_q;
  assign bus.missile_active = active_q;
  assign bus.is_missile     = active_q
                            & (abs_diff11(bus.DrawX, x_q) <= {1'b0, Missile_Half_W})
                            & (abs_diff11(bus.DrawY, y_q) <= {1'b0, Missile_Half_H});

endmodule

// File: tb/tb_player_missile.sv
// Randomised scoreboard bench for player_missile against a frame-level behavioural model.
module tb_player_missile;
  import game_pkg::*;

  logic Clk = 1'b0;
  logic Reset;
  always #5 Clk = ~Clk;

  player_missile_if bus ();

  player_missile dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  typedef struct {
    int x;
    int y;
    bit act;
    bit pix;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   dut_launches = 0;
  bit   mon_prev_act = 1'b0;

  // behavioural model: mode 0 waiting, 1 in flight, 2 reloading
  int m_mode, m_x, m_y, m_cool, m_launches;
  bit m_pending, m_prev_fire, m_valid;
  bit frame_hist[2];
  // inputs applied during the cycle that is about to end
  bit a_rst, a_frame, a_fire, a_hit;
  int a_px, a_py;
  int g_px, g_py;

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic int near(input int c, input int span);
    int v;
    v = c + int'($urandom_range(0, 2 * span)) - span;
    if (v < 0) v = 0;
    if (v > 1023) v = 1023;
    return v;
  endfunction

  task automatic model_update();
    bit tick, press;
    if (a_rst) begin
      m_mode = 0; m_x = 0; m_y = 0; m_cool = 0;
      m_pending = 0; m_prev_fire = 0;
      frame_hist[0] = 0; frame_hist[1] = 0;
      m_valid = 1;
    end else begin
      tick  = frame_hist[0] && !frame_hist[1];
      press = a_fire && !m_prev_fire;
      case (m_mode)
        0: begin
          if (tick && m_pending) begin
            m_mode = 1; m_x = a_px; m_y = a_py - 8; m_pending = 0; m_launches++;
          end else begin
            m_pending = m_pending || press;
          end
        end
        1: begin
          m_pending = 0;
          if (a_hit) begin
            m_mode = 2; m_cool = 15;
          end else if (tick) begin
            if (m_y - 8 < 0) begin m_mode = 2; m_cool = 15; end
            else m_y -= 8;
          end
        end
        default: begin
          m_pending = 0;
          if (tick) begin
            if (m_cool == 0) m_mode = 0;
            else m_cool--;
          end
        end
      endcase
      frame_hist[1] = frame_hist[0];
      frame_hist[0] = a_frame;
      m_prev_fire   = a_fire;
    end
  endtask

  task automatic step(input bit rst, input bit frm, input bit fr, input bit ht,
                      input int dx, input int dy);
    exp_t e;
    @(posedge Clk);
    #1;
    model_update();
    a_rst = rst; a_frame = frm; a_fire = fr; a_hit = ht; a_px = g_px; a_py = g_py;
    Reset            = rst;
    bus.frame_clk    = frm;
    bus.fire         = fr;
    bus.hit          = ht;
    bus.player_x_pos = 10'(g_px);
    bus.player_y_pos = 10'(g_py);
    bus.DrawX        = 10'(dx);
    bus.DrawY        = 10'(dy);
    if (m_valid) begin
      e.x   = m_x;
      e.y   = m_y;
      e.act = (m_mode == 1);
      e.pix = e.act && iabs(dx - m_x) <= 1 && iabs(dy - m_y) <= 4;
      sb.push_back(e);
    end
  endtask

  // one frame of 8 cycles; fire_mode 0 low, 1 held, 2 single-cycle press at pcyc
  task automatic frame(input int fire_mode, input int pcyc, input bit hit_tick, input bit hit_rand);
    bit f, h;
    for (int c = 0; c < 8; c++) begin
      f = (fire_mode == 1) || (fire_mode == 2 && c == pcyc);
      h = (hit_tick && c == 1) || (hit_rand && $urandom_range(0, 39) == 0);
      step(1'b0, c < 2, f, h, near(m_x, 2), near(m_y, 6));
    end
  endtask

  // monitor: compare every presented output sample with the queued expectation
  always @(negedge Clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      total++;
      if (bus.missile_x_pos !== e.x[9:0] || bus.missile_y_pos !== e.y[9:0] ||
          bus.missile_active !== e.act || bus.is_missile !== e.pix) begin
        bad++;
        $display("FAIL scoreboard t=%0t got x=%0d y=%0d act=%b pix=%b want x=%0d y=%0d act=%b pix=%b",
                 $time, bus.missile_x_pos, bus.missile_y_pos, bus.missile_active,
                 bus.is_missile, e.x, e.y, e.act, e.pix);
      end
      if (bus.missile_active === 1'b1 && !mon_prev_act) dut_launches++;
      mon_prev_act = (bus.missile_active === 1'b1);
    end
  end

  initial begin
    m_valid = 0; m_mode = 0; m_x = 0; m_y = 0; m_cool = 0; m_launches = 0;
    m_pending = 0; m_prev_fire = 0; frame_hist[0] = 0; frame_hist[1] = 0;
    a_rst = 1; a_frame = 0; a_fire = 0; a_hit = 0; a_px = 0; a_py = 8;
    g_px = 320; g_py = 450;
    Reset = 1'b1;
    bus.frame_clk = 1'b0; bus.fire = 1'b0; bus.hit = 1'b0;
    bus.player_x_pos = 10'd320; bus.player_y_pos = 10'd450;
    bus.DrawX = 10'd0; bus.DrawY = 10'd0;

    step(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
    frame(0, 0, 0, 0);
    frame(0, 0, 0, 0);

    // launch from (320,450): 442 then 434
    frame(2, 3, 0, 0);
    frame(0, 0, 0, 0);
    frame(0, 0, 0, 0);

    // pixel window around (320,434)
    step(1'b0, 1'b0, 1'b0, 1'b0, 321, 438);
    step(1'b0, 1'b0, 1'b0, 1'b0, 322, 434);
    step(1'b0, 1'b0, 1'b0, 1'b0, 320, 439);
    step(1'b0, 1'b0, 1'b0, 1'b0, 319, 430);
    step(1'b0, 1'b0, 1'b0, 1'b0, 320, 434);

    // hit coincident with tick, then 16 reload frames ignoring presses
    frame(0, 0, 1, 0);
    for (int i = 0; i < 16; i++) frame(2, 4, 0, 0);

    // relaunch and fly off the top, presses during reload ignored
    frame(2, 5, 0, 0);
    for (int i = 0; i < 60; i++) frame(0, 0, 0, 0);
    for (int i = 0; i < 18; i++) frame(2, i % 8, 0, 0);

    // reset mid-flight, then a lone tick must not launch
    frame(2, 2, 0, 0);
    for (int i = 0; i < 4; i++) frame(0, 0, 0, 0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
    for (int i = 0; i < 3; i++) frame(0, 0, 0, 0);

    // held fire for 200 frames gives exactly one launch
    dut_launches = 0;
    for (int i = 0; i < 200; i++) frame(1, 0, 0, 0);
    frame(0, 0, 0, 0);
    total++;
    if (dut_launches != 1) begin
      bad++;
      $display("FAIL held_fire_launches got=%0d want=1", dut_launches);
    end

    // random play
    for (int i = 0; i < 300; i++) begin
      g_px = $urandom_range(0, int'(SCREEN_W) - 1);
      g_py = $urandom_range(8, int'(SCREEN_H) - 1);
      frame($urandom_range(0, 2), $urandom_range(0, 7), $urandom_range(0, 7) == 0, 1'b1);
    end

    step(1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge Clk);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain left=%0d want=0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
